// File: rtl/seg_pkg.sv
// Shared constants for the 8-digit 7-segment scan controller:
// segment patterns, register map and slot-phase encoding.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EN   = 2'd1;
  localparam logic [1:0] ADDR_DP   = 2'd2;

  // Active-low {a,b,c,d,e,f,g,dp} patterns, entry n = hex digit n, dp off.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

  typedef enum logic {
    SLOT_BLANK,
    SLOT_DRIVE
  } slot_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// CPU-side register write port of the display scan controller.
interface seg_scan_ctrl_if;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern (dp bit = 1).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);
  assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode display with
// shadow registers committed only at frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 25000,
  parameter int BLANK_CYC = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  seg_scan_ctrl_if.slave  bus,
  output logic [7:0]      sseg_an,
  output logic [7:0]      sseg_ca,
  output logic            frame_done,
  output logic            pending
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       idx_reg;
  slot_state_t      state_reg, state_next;

  logic [31:0] data_sh_reg, data_sh_next, data_act_reg;
  logic [7:0]  en_sh_reg, en_sh_next, en_act_reg;
  logic [7:0]  dp_sh_reg, dp_sh_next, dp_act_reg;

  logic       slot_end;
  logic       frame_wrap;
  logic       wr_hit;
  logic [3:0] nibbles [NUM_DIGITS];
  logic [7:0] hex_seg;
  logic [7:0] an_next, ca_next;

  assign slot_end   = (cnt_reg == SLOT_LAST);
  assign frame_wrap = slot_end && (idx_reg == 3'd0);
  assign wr_hit     = bus.wr_en && (bus.wr_addr != 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nibbles[gi] = data_act_reg[4*gi +: 4];
    end
  endgenerate

  seg_hex_decode u_hex_decode (
    .nibble (nibbles[idx_reg]),
    .seg    (hex_seg)
  );

  // A write landing on the commit edge is merged here so it is committed too.
  always_comb begin
    data_sh_next = data_sh_reg;
    en_sh_next   = en_sh_reg;
    dp_sh_next   = dp_sh_reg;
    if (bus.wr_en) begin
      case (bus.wr_addr)
        ADDR_DATA: data_sh_next = bus.wr_data;
        ADDR_EN:   en_sh_next   = bus.wr_data[7:0];
        ADDR_DP:   dp_sh_next   = bus.wr_data[7:0];
        default:   ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    an_next    = SEG_BLANK;
    ca_next    = SEG_BLANK;
    case (state_reg)
      SLOT_BLANK: begin
        if (cnt_reg == BLANK_LAST) state_next = SLOT_DRIVE;
      end
      SLOT_DRIVE: begin
        if (slot_end) state_next = SLOT_BLANK;
        if (en_act_reg[idx_reg]) begin
          an_next = ~(8'h01 << idx_reg);
          ca_next = {hex_seg[7:1], ~dp_act_reg[idx_reg]};
        end
      end
      default: state_next = SLOT_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      idx_reg      <= 3'd7;
      state_reg    <= SLOT_BLANK;
      data_sh_reg  <= '0;
      en_sh_reg    <= 8'hFF;
      dp_sh_reg    <= 8'h00;
      data_act_reg <= '0;
      en_act_reg   <= 8'hFF;
      dp_act_reg   <= 8'h00;
      pending      <= 1'b0;
      frame_done   <= 1'b0;
      sseg_an      <= SEG_BLANK;
      sseg_ca      <= SEG_BLANK;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= slot_end ? '0 : cnt_reg + 1'b1;
      if (slot_end) idx_reg <= idx_reg - 3'd1;
      data_sh_reg <= data_sh_next;
      en_sh_reg   <= en_sh_next;
      dp_sh_reg   <= dp_sh_next;
      frame_done  <= frame_wrap;
      sseg_an     <= an_next;
      sseg_ca     <= ca_next;
      if (frame_wrap) begin
        data_act_reg <= data_sh_next;
        en_act_reg   <= en_sh_next;
        dp_act_reg   <= dp_sh_next;
        pending      <= 1'b0;
      end else if (wr_hit) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
